// File: rtl/sum_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3). Turns the adder's {cout, s} into
// decimal digits, one shift per clock, with a one-cycle valid pulse on completion.
module sum_bcd_converter #(
  parameter int unsigned IN_W   = 5,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  valid,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(IN_W + 1);
  localparam int unsigned AccW = 4 * DIGITS;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              r_state, w_state_next;
  logic [IN_W-1:0]     r_sh, w_sh_next, w_sh_shift;
  logic [AccW-1:0]     r_acc, w_acc_next, w_acc_corr, w_acc_shift;
  logic [AccW-1:0]     r_bcd, w_bcd_next;
  logic [CntW-1:0]     r_cnt, w_cnt_next;
  logic                r_valid, w_valid_next;
  logic [AccW+IN_W-1:0] w_cat;

  // Add-3 correction so each nibble carries into the next one on the shift
  always_comb begin
    w_acc_corr = r_acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_acc_corr[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    w_cat       = {w_acc_corr, r_sh} << 1;
    w_acc_shift = w_cat[AccW+IN_W-1:IN_W];
    w_sh_shift  = w_cat[IN_W-1:0];
  end

  always_comb begin
    w_state_next = r_state;
    w_sh_next    = r_sh;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_bcd_next   = r_bcd;
    w_valid_next = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_sh_next    = bin_in;
          w_acc_next   = '0;
          w_cnt_next   = CntW'(IN_W);
          w_state_next = StShift;
        end
      end
      StShift: begin
        w_sh_next  = w_sh_shift;
        w_acc_next = w_acc_shift;
        w_cnt_next = r_cnt - CntW'(1);
        if (r_cnt == CntW'(1)) begin
          w_bcd_next   = w_acc_shift;
          w_valid_next = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sh    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sh    <= w_sh_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_bcd   <= w_bcd_next;
      r_valid <= w_valid_next;
    end
  end

  assign bcd_out = r_bcd;
  assign valid   = r_valid;
  assign busy    = (r_state == StShift);

endmodule

// File: doc/sum_bcd_converter.md
Name: sum_bcd_converter

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly downstream of the 4-bit carry look-ahead adder on the DE2 lab board.
- Takes the 5-bit result {cout, s[3:0]} (0..31) and produces decimal digits.
- Each 4-bit digit then feeds its own binary_to_7seg decoder, so the sum is shown in decimal instead of hex.

Parameters:
- IN_W, 5, width of binary input.
- DIGITS, 2, number of BCD digits produced. Legal only if 10^DIGITS > 2^IN_W - 1; the default pair meets this.

Ports:
- clk  input  1  system clock (DE2 50 MHz); all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  request conversion of bin_in; honoured only while busy=0.
- bin_in  input  IN_W  binary value to convert; sampled only on the accepting edge.
- bcd_out  output  4*DIGITS  converted result; nibble i is decimal digit i (nibble 0 = ones). Holds its value until the next conversion completes.
- valid  output  1  one-cycle pulse: bcd_out was updated on the preceding edge.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset: rst_n=0 at a rising edge forces state=IDLE and clears all internal registers. Outputs after that edge: bcd_out=0, valid=0, busy=0. Reset overrides every other input, including mid-conversion; a conversion interrupted by reset is discarded and produces no valid pulse.
- Internal registers:
  - shift register sh (IN_W bits);
  - scratch register acc (4*DIGITS bits);
  - counter cnt, sized to hold IN_W.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - busy=0.
  - On an edge with start=1: sh<=bin_in, acc<=0, cnt<=IN_W, state<=SHIFT.
  - start=0: registers hold.
- SHIFT:
  - busy=1; start is ignored (not queued).
  - Each edge:
    1. Correct: every acc nibble with value >=5 gets +3 (4-bit add, no carry out of the nibble).
    2. Shift: {acc, sh} shifts left one bit as a single vector; sh LSB fills with 0.
    3. cnt<=cnt-1.
  - On the edge where cnt==1 (the last shift):
    - bcd_out <= corrected-and-shifted acc;
    - valid <= 1;
    - state <= IDLE.
- Latency: start accepted at edge k, shifts occur at edges k+1..k+IN_W. valid and busy=0 are visible in the cycle after edge k+IN_W, i.e. IN_W+1 edges after acceptance (6 at default).
- Back-to-back: start=1 during the valid cycle is accepted (state is IDLE), giving one conversion every IN_W+1 cycles.
- valid is high for exactly one cycle per completed conversion and is cleared on every other edge.
- bin_in changes after acceptance do not affect the conversion in flight.
- bcd_out never shows intermediate acc values; it changes only on the completing edge or on reset.
- Every output digit lies in 0..9 for any legal bin_in. At the default parameters the upper nibble is always 0..3.

Test Plan:
- Reset, then start with bin_in=5'd0 -> after 6 edges valid=1 for one cycle, bcd_out=8'h00, busy 1 for cycles 1..5 then 0.
- A=4'hF, B=4'hF, c0=1 through the adder, bin_in={cout,s}=31, start pulse -> bcd_out=8'h31 with valid at edge 6. Repeat with 19 -> 8'h19, 10 -> 8'h10, 9 -> 8'h09.
- Start with bin_in=22; at edge 2 drive start=1 with bin_in=7 -> ignored; single valid pulse, bcd_out=8'h22; no second valid.
- Start with bin_in=27; change bin_in to 3 at edge 2 -> result 8'h27.
- Convert 31 (bcd_out=8'h31); start bin_in=12; rst_n=0 at edge 3 -> bcd_out=8'h00, busy=0, valid=0. No valid pulse for 12 after reset release; bcd_out stays 0 until a new start.
- Sweep all 32 input values back-to-back, asserting start during each valid cycle -> 32 valid pulses spaced 6 cycles apart, each bcd_out equal to the decimal of its input; compare against a reference model.
